// File: rtl/aukv_dmem_bridge.sv
// Data-memory bridge: aligns core byte lanes onto a req/gnt/rvalid bus and returns
// right-justified load data with a one-cycle completion pulse, flagging misalignment and timeouts.
module aukv_dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_core_en,
  input  logic        i_core_we,
  input  logic [31:0] i_core_addr,
  input  logic [3:0]  i_core_strobe,
  input  logic [31:0] i_core_data,
  output logic [31:0] o_core_data,
  output logic        o_core_valid,
  output logic        o_core_err,
  output logic        o_busy,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_off;
  logic [15:0] r_cnt;

  logic [1:0]  w_off;
  logic        w_misal;
  logic        w_tmo;

  assign w_off   = i_core_addr[1:0];
  assign w_misal = ((i_core_strobe == 4'h3) && (w_off == 2'd3)) ||
                   ((i_core_strobe == 4'hf) && (w_off != 2'd0));
  // Counter starts at 0 on state entry, so the limit is hit in the TIMEOUT_CYCLES-th cycle.
  assign w_tmo   = (TIMEOUT_CYCLES != 0) && (r_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state      <= S_IDLE;
      r_off        <= '0;
      r_cnt        <= '0;
      o_core_data  <= '0;
      o_core_valid <= 1'b0;
      o_core_err   <= 1'b0;
      o_busy       <= 1'b0;
      o_bus_req    <= 1'b0;
      o_bus_we     <= 1'b0;
      o_bus_addr   <= '0;
      o_bus_be     <= '0;
      o_bus_wdata  <= '0;
    end else begin
      o_core_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_core_en) begin
            o_busy <= 1'b1;
            if (w_misal) begin
              r_state      <= S_DONE;
              o_core_valid <= 1'b1;
              o_core_err   <= 1'b1;
            end else if (i_core_strobe == 4'h0) begin
              r_state      <= S_DONE;
              o_core_valid <= 1'b1;
              o_core_err   <= 1'b0;
            end else begin
              r_state     <= S_REQ;
              r_off       <= w_off;
              r_cnt       <= '0;
              o_core_err  <= 1'b0;
              o_bus_req   <= 1'b1;
              o_bus_we    <= i_core_we;
              o_bus_addr  <= {i_core_addr[31:2], 2'b00};
              o_bus_be    <= 4'(i_core_strobe << w_off);
              o_bus_wdata <= i_core_data << {w_off, 3'b000};
            end
          end
        end
        S_REQ: begin
          if (i_bus_gnt) begin
            o_bus_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_WAIT;
          end else if (w_tmo) begin
            o_bus_req    <= 1'b0;
            o_core_valid <= 1'b1;
            o_core_err   <= 1'b1;
            o_core_data  <= '0;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_WAIT: begin
          if (i_bus_rvalid) begin
            if (!o_bus_we) begin
              o_core_data <= i_bus_rdata >> {r_off, 3'b000};
            end
            o_core_valid <= 1'b1;
            r_state      <= S_DONE;
          end else if (w_tmo) begin
            o_core_valid <= 1'b1;
            o_core_err   <= 1'b1;
            o_core_data  <= '0;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
